// File: rtl/alu4_nibble_seq.sv
// Multi-precision sequencer: issues one wide operation to a shared 4-bit ALU
// one nibble per cycle, chaining math and rotate carries between nibbles.
module alu4_nibble_seq #(
   parameter int NIBBLES = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic [3:0]             opcode,
   input  logic                   msb_first,
   input  logic [4*NIBBLES-1:0]   a,
   input  logic [4*NIBBLES-1:0]   b,
   input  logic                   carry_in,
   input  logic                   rot_in,
   output logic [3:0]             alu_a,
   output logic [3:0]             alu_b,
   output logic [3:0]             alu_op,
   output logic                   alu_cin,
   output logic                   alu_rin,
   input  logic [3:0]             alu_out,
   input  logic                   alu_cout,
   input  logic                   alu_rout,
   input  logic                   alu_ovf,
   output logic                   busy,
   output logic                   done,
   output logic [4*NIBBLES-1:0]   result,
   output logic                   carry_out,
   output logic                   rot_out,
   output logic                   overflow,
   output logic                   zero
);

   localparam int W  = 4 * NIBBLES;
   localparam int IW = $clog2(NIBBLES);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]    state;
   logic [IW-1:0] idx;
   logic [W-1:0]  a_q;
   logic [W-1:0]  b_q;
   logic [3:0]    op_q;
   logic          msbf_q;
   logic          cchain;
   logic          rchain;
   logic          zacc;
   logic          run;
   logic          accept;
   logic          last;

   assign run    = (state == RUN);
   assign accept = start && (state != RUN);
   assign busy   = run;
   assign done   = (state == DONE);

   // Final nibble is detected before stepping, so idx never wraps
   assign last = msbf_q ? (idx == '0) : (idx == IW'(NIBBLES - 1));

   always_comb begin
      alu_a   = 4'd0;
      alu_b   = 4'd0;
      alu_op  = 4'd0;
      alu_cin = 1'b0;
      alu_rin = 1'b0;
      if (run) begin
         alu_a   = a_q[4*idx +: 4];
         alu_b   = b_q[4*idx +: 4];
         alu_op  = op_q;
         alu_cin = cchain;
         alu_rin = rchain;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         idx       <= '0;
         a_q       <= '0;
         b_q       <= '0;
         op_q      <= 4'd0;
         msbf_q    <= 1'b0;
         cchain    <= 1'b0;
         rchain    <= 1'b0;
         zacc      <= 1'b0;
         result    <= '0;
         carry_out <= 1'b0;
         rot_out   <= 1'b0;
         overflow  <= 1'b0;
         zero      <= 1'b0;
      end else if (accept) begin
         state  <= RUN;
         a_q    <= a;
         b_q    <= b;
         op_q   <= opcode;
         msbf_q <= msb_first;
         idx    <= msb_first ? IW'(NIBBLES - 1) : '0;
         cchain <= carry_in;
         rchain <= rot_in;
         zacc   <= 1'b1;
      end else begin
         unique case (state)
            RUN: begin
               result[4*idx +: 4] <= alu_out;
               cchain <= alu_cout;
               rchain <= alu_rout;
               zacc   <= zacc & (alu_out == 4'd0);
               if (last) begin
                  state     <= DONE;
                  carry_out <= alu_cout;
                  rot_out   <= alu_rout;
                  overflow  <= alu_ovf;
                  zero      <= zacc & (alu_out == 4'd0);
               end else begin
                  idx <= msbf_q ? idx - 1'b1 : idx + 1'b1;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu4_nibble_seq.sv
// Directed bench for alu4_nibble_seq with a behavioural 4-bit ALU model
// on the alu_* pins (opcode 0 = add with carry, 1 = rotate right through carry).
module tb_alu4_nibble_seq;

   localparam int N = 4;
   localparam int W = 4 * N;
   localparam logic [3:0] OP_ADD = 4'h0;
   localparam logic [3:0] OP_RRC = 4'h1;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [3:0]    opcode;
   logic          msb_first;
   logic [W-1:0]  a;
   logic [W-1:0]  b;
   logic          carry_in;
   logic          rot_in;
   logic [3:0]    alu_a;
   logic [3:0]    alu_b;
   logic [3:0]    alu_op;
   logic          alu_cin;
   logic          alu_rin;
   logic [3:0]    alu_out;
   logic          alu_cout;
   logic          alu_rout;
   logic          alu_ovf;
   logic          busy;
   logic          done;
   logic [W-1:0]  result;
   logic          carry_out;
   logic          rot_out;
   logic          overflow;
   logic          zero;

   int checks = 0;
   int errors = 0;

   logic [4:0] sum;

   alu4_nibble_seq #(.NIBBLES(N)) dut (
      .clk(clk), .rst(rst), .start(start), .opcode(opcode),
      .msb_first(msb_first), .a(a), .b(b),
      .carry_in(carry_in), .rot_in(rot_in),
      .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
      .alu_cin(alu_cin), .alu_rin(alu_rin),
      .alu_out(alu_out), .alu_cout(alu_cout),
      .alu_rout(alu_rout), .alu_ovf(alu_ovf),
      .busy(busy), .done(done), .result(result),
      .carry_out(carry_out), .rot_out(rot_out),
      .overflow(overflow), .zero(zero)
   );

   always #5 clk = ~clk;

   always_comb begin
      sum      = 5'd0;
      alu_out  = 4'd0;
      alu_cout = 1'b0;
      alu_rout = 1'b0;
      alu_ovf  = 1'b0;
      case (alu_op)
         OP_ADD: begin
            sum      = {1'b0, alu_a} + {1'b0, alu_b} + {4'd0, alu_cin};
            alu_out  = sum[3:0];
            alu_cout = sum[4];
            alu_ovf  = (alu_a[3] == alu_b[3]) && (sum[3] != alu_a[3]);
         end
         OP_RRC: begin
            alu_out  = {alu_rin, alu_a[3:1]};
            alu_rout = alu_a[0];
         end
         default: ;
      endcase
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, " busy"}, 32'(busy), 32'd0);
      chk({tag, " done"}, 32'(done), 32'd0);
      chk({tag, " drive"},
          {13'd0, alu_a, alu_b, alu_op, alu_cin, alu_rin}, 32'd0);
   endtask

   // Issue one op, check the alu_a nibble sequence, then the DONE cycle
   task automatic do_op(input string tag, input logic [3:0] op,
                        input logic mf, input logic [W-1:0] va,
                        input logic [W-1:0] vb, input logic ci,
                        input logic ri, input logic [15:0] seq,
                        input logic [W-1:0] res, input logic [3:0] flg);
      opcode = op; msb_first = mf; a = va; b = vb;
      carry_in = ci; rot_in = ri; start = 1'b1;
      step();
      start = 1'b0;
      for (int i = 0; i < N; i++) begin
         chk({tag, " busy"}, 32'(busy), 32'd1);
         chk({tag, " alu_a"}, 32'(alu_a), 32'(seq[15-4*i -: 4]));
         step();
      end
      chk({tag, " done"}, 32'(done), 32'd1);
      chk({tag, " busy@done"}, 32'(busy), 32'd0);
      chk({tag, " result"}, 32'(result), 32'(res));
      chk({tag, " cout/rout/ovf/zero"},
          32'({carry_out, rot_out, overflow, zero}), 32'(flg));
      step();
      chk({tag, " done gone"}, 32'(done), 32'd0);
      chk({tag, " result hold"}, 32'(result), 32'(res));
   endtask

   int          ndone;
   int          dcyc [2];
   logic [W-1:0] dres [2];

   initial begin
      rst = 1'b1; start = 1'b1; opcode = OP_ADD; msb_first = 1'b0;
      a = 16'hFFFF; b = 16'hFFFF; carry_in = 1'b1; rot_in = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         step();
         chk_idle("reset");
         chk("reset result", 32'(result), 32'd0);
         chk("reset flags",
             32'({carry_out, rot_out, overflow, zero}), 32'd0);
      end
      rst = 1'b0; start = 1'b0;
      step();
      chk_idle("idle");
      chk("idle result", 32'(result), 32'd0);

      do_op("add16", OP_ADD, 1'b0, 16'h1234, 16'h0FCD, 1'b0, 1'b0,
            16'h4321, 16'h2201, 4'b0000);
      do_op("ripple", OP_ADD, 1'b0, 16'hFFFF, 16'h0001, 1'b0, 1'b0,
            16'hFFFF, 16'h0000, 4'b1001);
      do_op("adc", OP_ADD, 1'b0, 16'h7FFF, 16'h0000, 1'b1, 1'b0,
            16'hFFF7, 16'h8000, 4'b0010);
      do_op("rrc", OP_RRC, 1'b1, 16'h8001, 16'h0000, 1'b0, 1'b0,
            16'h8001, 16'h4000, 4'b0100);
      chk_idle("post rrc");

      // Back-to-back with start held through RUN
      ndone = 0;
      opcode = OP_ADD; msb_first = 1'b0; carry_in = 1'b0; rot_in = 1'b0;
      a = 16'h0001; b = 16'h0001; start = 1'b1;
      for (int k = 1; k <= 14; k++) begin
         step();
         if (done) begin
            if (ndone < 2) begin
               dcyc[ndone] = k;
               dres[ndone] = result;
            end
            ndone++;
         end
         if (k == 1) begin
            a = 16'hFFFF; b = 16'hFFFF;
         end
         if (k == 5) begin
            a = 16'h0002; b = 16'h0003;
         end
         if (k == 6) start = 1'b0;
      end
      chk("b2b done count", 32'(ndone), 32'd2);
      chk("b2b first cycle", 32'(dcyc[0]), 32'd5);
      chk("b2b first result", 32'(dres[0]), 32'h0002);
      chk("b2b spacing", 32'(dcyc[1] - dcyc[0]), 32'd5);
      chk("b2b second result", 32'(dres[1]), 32'h0005);

      // Reset during the second RUN cycle
      a = 16'h1234; b = 16'h0FCD; start = 1'b1;
      step();
      start = 1'b0;
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk_idle("midrst");
      chk("midrst result", 32'(result), 32'd0);
      ndone = 0;
      for (int k = 0; k < 6; k++) begin
         if (done) ndone++;
         step();
      end
      chk("midrst no done", 32'(ndone), 32'd0);
      do_op("after rst", OP_ADD, 1'b0, 16'h1234, 16'h0FCD, 1'b0, 1'b0,
            16'h4321, 16'h2201, 4'b0000);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/alu4_nibble_seq.md
Name: alu4_nibble_seq

Overview:
Multi-precision sequencer for the 4-bit ALU. It accepts one wide operation, issues it to the shared combinational 4-bit ALU one nibble per cycle, and chains the math and rotate carries between nibbles. It assembles the wide result and wide flags, then pulses done. It sits between the top-level I/O and the ALU instance and owns the ALU input pins exclusively.

Parameters:
NIBBLES, 4, number of nibbles per operation (word width W = 4*NIBBLES); legal range 2..8.

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
start  input  1  request; accepted only when busy=0
opcode  input  4  ALU opcode, held constant for every nibble of the operation
msb_first  input  1  0: nibbles issued LSB to MSB (add, sub, shift-left); 1: MSB to LSB (shift/rotate-right)
a  input  W  operand A, latched on accept
b  input  W  operand B, latched on accept
carry_in  input  1  math carry into the first issued nibble
rot_in  input  1  rotate carry into the first issued nibble
alu_a  output  4  ALU inputA nibble
alu_b  output  4  ALU inputB nibble
alu_op  output  4  ALU opcode
alu_cin  output  1  ALU math_carry_in
alu_rin  output  1  ALU rot_carry_in
alu_out  input  4  ALU result nibble (combinational, same cycle)
alu_cout  input  1  ALU math_carry_out
alu_rout  input  1  ALU rot_carry_out
alu_ovf  input  1  ALU overflow_out
busy  output  1  operation in progress
done  output  1  one-cycle pulse; result and flags are valid
result  output  W  assembled result
carry_out  output  1  math carry from the last issued nibble
rot_out  output  1  rotate carry from the last issued nibble
overflow  output  1  alu_ovf of the last issued nibble
zero  output  1  1 when result == 0

Behaviour:
- FSM states: IDLE, RUN, DONE.
- IDLE/DONE with start=1: latch a, b, opcode, msb_first. Set idx to 0 (msb_first=0) or NIBBLES-1 (msb_first=1). Load cchain=carry_in and rchain=rot_in. Go to RUN.
- DONE with start=0: go to IDLE.
- RUN drives the ALU as follows:
  - alu_a = A[idx], alu_b = B[idx] (nibble slices).
  - alu_op = opcode, alu_cin = cchain, alu_rin = rchain.
- At the end of each RUN cycle:
  - result[idx] <= alu_out.
  - cchain <= alu_cout, rchain <= alu_rout, last_ovf <= alu_ovf.
  - zacc <= zacc & (alu_out == 0).
  - Step idx toward the far end.
- The cycle that processes the final nibble also transitions to DONE.
- DONE: done=1 for exactly one cycle. carry_out=cchain, rot_out=rchain, overflow=last_ovf, zero=zacc.
- busy=1 in RUN only. busy=0 and done=0 in IDLE.
- Latency: start accepted in cycle 0. RUN covers cycles 1..NIBBLES. done is high in cycle NIBBLES+1.
- Back-to-back: start during the DONE cycle is accepted, giving RUN in the next cycle. Throughput is one operation per NIBBLES+1 cycles.
- start while busy=1 is ignored; latched operands and opcode do not change.
- Outside RUN, alu_a/alu_b/alu_op/alu_cin/alu_rin are driven 0.
- result and the flags hold their values from the end of DONE until the next accept.
- Flags are registered and change only on the DONE transition. The result register updates nibble by nibble during RUN.
- Reset (any state, including mid-RUN): state=IDLE, idx=0, busy=0, done=0, result=0, carry_out=0, rot_out=0, overflow=0, zero=0, cchain=0, rchain=0, ALU drive=0. A partial operation is discarded with no done pulse.
- Index arithmetic: idx width is ceil(log2(NIBBLES)) bits. idx never wraps, because termination is detected at the final nibble before stepping.

Test Plan:
The bench uses a behavioural 4-bit ALU model wired to the alu_* ports and checks each scenario against a W-bit reference.
- Reset, then idle: hold rst 2 cycles with start=1 -> busy=0, done=0, result=0, all flags 0, alu_* = 0 throughout.
- 16-bit add: a=0x1234, b=0x0FCD, carry_in=0, msb_first=0, ADD opcode -> alu_a sequence 4,3,2,1 in cycles 1-4. In cycle 5: done=1, result=0x2201, carry_out=0, zero=0, overflow=0.
- Carry ripple to zero: a=0xFFFF, b=0x0001, ADD, carry_in=0 -> result=0x0000, carry_out=1, zero=1, overflow=0. Add-with-carry: a=0x7FFF, b=0x0000, carry_in=1 -> result=0x8000, overflow=1.
- Rotate right through carry: a=0x8001, rot_in=0, msb_first=1, rotate-right opcode -> alu_a sequence 8,0,0,1. Final result=0x4000, rot_out=1.
- Back-to-back with ignored start: first op ADD 0x0001+0x0001, start held high through RUN, second op a=0x0002, b=0x0003 presented during DONE -> first result=0x0002 and second result=0x0005. Exactly two done pulses, 5 cycles apart.
- Reset mid-operation: assert rst in the cycle-2 RUN cycle of 0x1234+0x0FCD -> the next cycle is IDLE with result=0. No done pulse. A new start then completes normally with the correct result.
